// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: shared prescale counter, four power-of-two tick channels.
// Optional CFG_SYNC_UPDATE_EN defers divisor updates to the counter wrap edge.
module clk_en_sched #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             cfg_valid_i,
   output logic             cfg_ready_o,
   input  logic [1:0]       cfg_ch_i,
   input  logic [3:0]       cfg_div_i,
   output logic [3:0]       tick_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] cnt_o
);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   localparam logic [3:0] DIV_MAX = (CNT_W > 15) ? 4'd15 : 4'(CNT_W);

   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       div_q [4];
   state_t           state_q, state_d;
   logic [1:0]       sh_ch_q;
   logic [3:0]       sh_div_q;
   logic [3:0]       div_clamped;
   logic             accept;
   logic             apply;
   logic             apply_ok;

`ifdef CFG_SYNC_UPDATE_EN
   // Apply only on the edge where the counter wraps to zero.
   assign apply_ok = (cnt_q == '1);
`else
   assign apply_ok = 1'b1;
`endif

   always_comb begin
      div_clamped = cfg_div_i;
      if (cfg_div_i > DIV_MAX) begin
         div_clamped = DIV_MAX;
      end
   end

   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      apply       = 1'b0;
      cfg_ready_o = 1'b0;
      busy_o      = 1'b0;
      case (state_q)
         IDLE: begin
            cfg_ready_o = 1'b1;
            if (cfg_valid_i) begin
               accept  = 1'b1;
               state_d = PEND;
            end
         end
         PEND: begin
            busy_o = 1'b1;
            if (apply_ok) begin
               apply   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sh_ch_q  <= '0;
         sh_div_q <= '0;
      end else if (accept) begin
         sh_ch_q  <= cfg_ch_i;
         sh_div_q <= div_clamped;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int unsigned c = 0; c < 4; c++) begin
            div_q[c] <= '0;
         end
      end else if (apply) begin
         div_q[sh_ch_q] <= sh_div_q;
      end
   end

   // A channel ticks when the low div bits of the counter are all zero.
   always_comb begin
      tick_o = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         tick_o[c] = (div_q[c] != '0);
         for (int unsigned i = 0; i < CNT_W; i++) begin
            if ((i < 32'(div_q[c])) && cnt_q[i]) begin
               tick_o[c] = 1'b0;
            end
         end
      end
   end

   assign cnt_o = cnt_q;

endmodule
